// File: rtl/rom_stream_reader_pkg.sv
// rom_stream_reader_pkg: shared ROM geometry and reader FSM encoding
package rom_stream_reader_pkg;
  localparam int ROM_ADDR_W = 2;
  localparam int ROM_DATA_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
endpackage

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: control, ROM and stream signals of the reader
interface rom_stream_reader_if #(
  parameter int ADDR_W = rom_stream_reader_pkg::ROM_ADDR_W,
  parameter int DATA_W = rom_stream_reader_pkg::ROM_DATA_W
);
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0] length;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  logic [DATA_W+ADDR_W-1:0] checksum;
  modport master (
    input start, start_addr, length, rom_data, out_ready,
    output rom_addr, out_data, out_valid, busy, done, checksum
  );
  modport slave (
    output start, start_addr, length, rom_data, out_ready,
    input rom_addr, out_data, out_valid, busy, done, checksum
  );
endinterface

// File: rtl/rom_stream_fifo2.sv
// rom_stream_fifo2: 2-entry FIFO with valid/ready output and same-cycle push/pop
module rom_stream_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         pop,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, wr;
  assign valid = count != 2'd0;
  assign pop = valid && ready;
  assign data = mem[rp];
  assign wr = push && (count != 2'd2 || pop);
  always_ff @(posedge clk)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr) begin
        mem[wp] <= push_data;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, wr} - {1'b0, pop};
    end
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: issues a run of ROM reads and streams the captured words with a checksum
module rom_stream_reader import rom_stream_reader_pkg::*; #(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input logic clk,
  input logic rst,
  rom_stream_reader_if.master bus
);
  localparam logic [ADDR_W:0] ONE = 1;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] rd_rem, dl_rem;
  logic [DATA_W+ADDR_W-1:0] sum;
  logic inflight, busy, done, pop, issue;
  logic [1:0] count;
  // rom_addr is the address counter; a cycle counts as a read only when issue is high
  always_comb issue = state == S_RUN && rd_rem != '0 && ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign bus.rom_addr = addr;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.checksum = sum;
  rom_stream_fifo2 #(.W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .push_data(bus.rom_data),
    .ready(bus.out_ready),
    .valid(bus.out_valid),
    .data(bus.out_data),
    .pop(pop),
    .count(count)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      addr <= '0;
      rd_rem <= '0;
      dl_rem <= '0;
      sum <= '0;
      inflight <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      inflight <= issue;
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          addr <= bus.start_addr;
          rd_rem <= bus.length;
          dl_rem <= bus.length;
          sum <= '0;
          state <= bus.length == '0 ? S_FIN : S_RUN;
          busy <= bus.length != '0;
          done <= bus.length == '0;
        end
        S_RUN: begin
          if (issue) begin
            addr <= addr + 1'b1;
            rd_rem <= rd_rem - 1'b1;
          end
          if (pop) begin
            sum <= sum + {{ADDR_W{1'b0}}, bus.out_data};
            dl_rem <= dl_rem - 1'b1;
            if (dl_rem == ONE) begin
              state <= S_FIN;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream address sequencer and downstream data collector for the 4x4 synchronous-read ROM.
- On a start pulse it issues a run of consecutive ROM addresses. It captures the registered ROM output, which arrives one cycle after the address.
- Captured words are delivered on a valid/ready stream with backpressure, and a running checksum is kept.
- Sits between the control logic and the ROM data consumers.

Parameters:
- ADDR_W, 2, ROM address width; ROM depth = 2**ADDR_W.
- DATA_W, 4, ROM word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first ROM address of the run.
- length  in  ADDR_W+1  number of words to read, 0..2**ADDR_W.
- rom_addr  out  ADDR_W  address to ROM (registered).
- rom_data  in  DATA_W  ROM registered output; valid the cycle after rom_addr is sampled.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- checksum  out  DATA_W+ADDR_W  sum of words delivered in the current or last run; modulo 2**(DATA_W+ADDR_W), which cannot overflow for legal length.

Behaviour:
- Reset values: rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0.
  - Internal state is also cleared: FSM=IDLE, read count, in-flight flag, output buffer.
  - rst mid-run aborts immediately; no further words are delivered and no done pulse is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE: when start=1, latch start_addr into the address counter, latch length, clear checksum, and go to RUN. busy=1 from the next cycle.
  - IDLE with start=1 and length=0: go directly to FIN; no ROM read and no stream output.
  - RUN: issue reads. Go to FIN on the cycle the last word completes its out_valid&&out_ready handshake.
  - FIN: done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start while busy or in FIN is ignored.
- Read issue:
  - The output buffer is 2 deep. A read is issued in a cycle when reads_remaining>0 and (buffer_count + inflight - pop) < 2, where pop = out_valid&&out_ready.
  - Issuing a read means rom_addr holds the issued address for that cycle and the in-flight flag is set. rom_data is captured into the buffer on the following posedge.
  - The address counter increments by 1 after each issue and wraps modulo 2**ADDR_W (e.g. 3 -> 0).
- Latency with out_ready held high:
  - start sampled at edge 0.
  - rom_addr = start_addr in cycle 1.
  - First out_valid in cycle 3.
  - Then one word per cycle.
- Stream rules:
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - Words are delivered in address order, with no drops or duplicates.
  - Push and pop in the same cycle are legal.
- checksum adds out_data on each handshake and holds its value after done until the next accepted start.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN, FIN).
  - Default ADDR_W/DATA_W constants, shared with the ROM.
- One natural sub-module: rom_stream_fifo2, a 2-entry FIFO with push/pop, count, valid/ready, and simultaneous push/pop support.

Test Plan:
All scenarios load ROM with mem[0]=0x3, mem[1]=0xA, mem[2]=0x5, mem[3]=0xF.
- start_addr=1, length=3, out_ready=1 -> out_data 0xA,0x5,0xF on consecutive cycles starting 3 cycles after start; checksum=30; done one cycle after last handshake; busy low in the done cycle.
- start_addr=3, length=3 (wrap) -> 0xF,0x3,0xA; rom_addr sequence 3,0,1; checksum=28.
- start_addr=0, length=4, out_ready pattern 1,0,0,1,0,1,1,... -> exactly 0x3,0xA,0x5,0xF; out_data stable while stalled; at most 2 reads outstanding plus buffered; checksum=33.
- length=0 start -> done pulse with no out_valid; checksum=0.
- Second start during RUN (start_addr=2, length=1) -> ignored; original run completes unchanged.
- rst asserted after first word of a 4-word run -> next cycle all outputs are at reset values; a new run start_addr=2, length=2 afterwards yields 0x5,0xF with checksum=20.
